// File: rtl/lvl_scan_gen_if.sv
// Level/scan bundle between the game logic, lvl_scan_gen and the 4-digit decoder.
// master: the side issuing level requests and watching the display/level outputs.
// slave : lvl_scan_gen itself.
interface lvl_scan_gen_if;
    logic       lvl_up;   // single-cycle request: advance level by one
    logic       lvl_clr;  // single-cycle request: return level to 0
    logic [1:0] scan;     // digit select to decoder
    logic [3:0] din;      // frame-stable level digit to decoder
    logic [3:0] level;    // live level register
    logic       at_max;   // level == LVL_MAX

    modport master (
        output lvl_up,
        output lvl_clr,
        input  scan,
        input  din,
        input  level,
        input  at_max
    );

    modport slave (
        input  lvl_up,
        input  lvl_clr,
        output scan,
        output din,
        output level,
        output at_max
    );
endinterface

// File: rtl/lvl_scan_gen.sv
// lvl_scan_gen: level register plus digit-scan sequencer for the "L-0n" display.
//   - prescaler divides clk into a one-cycle scan tick every DIV cycles
//   - scan slot sequencer walks 00 -> 01 -> 10 -> 11 -> 00 on each tick
//   - level register with clear/advance requests (clear has priority)
//   - din shadows the level once per frame so the decoder never sees a mid-frame change
// Optional build macro LVL_WRAP_EN: lvl_up at LVL_MAX wraps the level to 0 instead
// of saturating.
module lvl_scan_gen #(
    parameter  int DIV     = 50000,
    parameter  int LVL_MAX = 9,
    localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic            clk,
    input  logic            rst,
    lvl_scan_gen_if.slave   bus
);

    localparam logic [3:0] LVL_TOP = 4'(LVL_MAX);

    // Slot order matches the decoder's digit select encoding.
    typedef enum logic [1:0] {
        SLOT_LVL  = 2'b00,   // level digit
        SLOT_ZERO = 2'b01,   // '0'
        SLOT_DASH = 2'b10,   // '-'
        SLOT_L    = 2'b11    // 'L'
    } slot_t;

    logic       tick;
    logic       frame_end;
    slot_t      slot_reg;
    slot_t      slot_next;
    logic [3:0] level_reg;
    logic [3:0] level_next;
    logic [3:0] din_reg;

    // ------------------------------------------------------------------
    // Prescaler: tick is high on the last cycle of every DIV-cycle slot.
    // With DIV = 1 every cycle is the last one, so no counter is needed.
    // ------------------------------------------------------------------
    generate
        if (DIV == 1) begin : g_no_div
            assign tick = 1'b1;
        end else begin : g_div
            localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] cnt_next;

            // Next prescaler value: count up, fold back to 0 after the last cycle.
            always_comb begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CNT_LAST) begin
                    cnt_next = '0;
                end
            end

            // Prescaler register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign tick = (cnt_reg == CNT_LAST);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Scan slot sequencer (two-process FSM).
    // ------------------------------------------------------------------

    // Slot state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_reg <= SLOT_LVL;
        end else begin
            slot_reg <= slot_next;
        end
    end

    // Next slot on tick; frame_end marks the tick that leaves the 'L' slot.
    always_comb begin
        slot_next = slot_reg;
        frame_end = 1'b0;
        if (tick) begin
            case (slot_reg)
                SLOT_LVL:  slot_next = SLOT_ZERO;
                SLOT_ZERO: slot_next = SLOT_DASH;
                SLOT_DASH: slot_next = SLOT_L;
                SLOT_L: begin
                    slot_next = SLOT_LVL;
                    frame_end = 1'b1;
                end
                default:   slot_next = SLOT_LVL;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Level register: clear beats advance; advance at the top either
    // saturates or wraps depending on the build.
    // ------------------------------------------------------------------

    // Next level from the request inputs.
    always_comb begin
        level_next = level_reg;
        if (bus.lvl_clr) begin
            level_next = 4'd0;
        end else if (bus.lvl_up) begin
            if (level_reg < LVL_TOP) begin
                level_next = level_reg + 4'd1;
            end else begin
`ifdef LVL_WRAP_EN
                level_next = 4'd0;
`else
                level_next = level_reg;
`endif
            end
        end
    end

    // Level register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_reg <= 4'd0;
        end else begin
            level_reg <= level_next;
        end
    end

    // ------------------------------------------------------------------
    // Display shadow: captures the pre-edge level only at the frame
    // boundary, so din is constant for a whole 4-slot frame.
    // ------------------------------------------------------------------

    // din shadow register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_reg <= 4'd0;
        end else if (frame_end) begin
            din_reg <= level_reg;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: scan and din come straight from registers.
    // ------------------------------------------------------------------
    assign bus.scan   = slot_reg;
    assign bus.din    = din_reg;
    assign bus.level  = level_reg;
    assign bus.at_max = (level_reg == LVL_TOP);

endmodule

// File: tb/tb_lvl_scan_gen.sv
// Self-checking bench for lvl_scan_gen: DIV=4 instance for the main tests,
// DIV=1 instance for the every-cycle scan case. Build with +define+LVL_WRAP_EN
// on both RTL and bench to check the wrap variant.
module tb_lvl_scan_gen;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst1 = 1'b1;

    always #5 clk = ~clk;

    lvl_scan_gen_if bus4 ();
    lvl_scan_gen_if bus1 ();

    lvl_scan_gen #(.DIV(4), .LVL_MAX(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    lvl_scan_gen #(.DIV(1), .LVL_MAX(9)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1.slave)
    );

    typedef struct {
        logic up;
        logic clr;
        int   exp_lvl;
        int   exp_max;
    } vec_t;

    vec_t tbl [18];

    int n_checks = 0;
    int n_fail   = 0;
    int k        = 0;   // DIV=4 edges since reset release
    int k1       = 0;   // DIV=1 edges since reset release

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    initial begin
        int lv;
        int guard;
        int exp_din;

        // ---------------- vector table (level starts at 3) ----------------
        tbl[0] = '{1'b1, 1'b0, 4, 0};
        tbl[1] = '{1'b1, 1'b0, 5, 0};
        tbl[2] = '{1'b1, 1'b1, 0, 0};   // clear wins over up at level 5
        tbl[3] = '{1'b0, 1'b1, 0, 0};
        for (int i = 0; i < 12; i++) begin
`ifdef LVL_WRAP_EN
            lv = (i < 9) ? i + 1 : i - 9;   // 10th pulse -> 0, 12th -> 2
`else
            lv = (i < 9) ? i + 1 : 9;       // saturates at 9
`endif
            tbl[4 + i] = '{1'b1, 1'b0, lv, (lv == 9) ? 1 : 0};
        end
        tbl[16] = '{1'b1, 1'b1, 0, 0};
        tbl[17] = '{1'b0, 1'b0, 0, 0};

        bus4.lvl_up  = 1'b0;
        bus4.lvl_clr = 1'b0;
        bus1.lvl_up  = 1'b0;
        bus1.lvl_clr = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        chk("rst_scan",   int'(bus4.scan),   0);
        chk("rst_din",    int'(bus4.din),    0);
        chk("rst_level",  int'(bus4.level),  0);
        chk("rst_at_max", int'(bus4.at_max), 0);

        // ---------------- test 1: idle scan ----------------
        @(negedge clk);
        rst = 1'b0;
        k   = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            chk("idle_scan", int'(bus4.scan), (k / 4) % 4);
        end
        $display("idle: 32 cycles scanned, scan=%0d din=%0d", bus4.scan, bus4.din);
        chk("idle_din",   int'(bus4.din),   0);
        chk("idle_level", int'(bus4.level), 0);

        // ---------------- test 2: mid-frame pulses, frame-stable din ----------------
        repeat (5) step();                 // k = 37, slot 01
        bus4.lvl_up = 1'b1;
        repeat (3) step();                 // k = 40
        bus4.lvl_up = 1'b0;
        $display("pulse x3: level=%0d din=%0d", bus4.level, bus4.din);
        chk("pulse_level", int'(bus4.level), 3);
        chk("pulse_din_hold", int'(bus4.din), 0);
        while (k < 47) step();
        chk("pre_bnd_scan", int'(bus4.scan), 3);
        chk("pre_bnd_din",  int'(bus4.din),  0);
        step();                            // k = 48, frame boundary
        $display("boundary: scan=%0d din=%0d", bus4.scan, bus4.din);
        chk("bnd_scan", int'(bus4.scan), 0);
        chk("bnd_din",  int'(bus4.din),  3);

        // ---------------- tests 3/4: table-driven level vectors ----------------
        for (int i = 0; i < 18; i++) begin
            bus4.lvl_up  = tbl[i].up;
            bus4.lvl_clr = tbl[i].clr;
            step();
            $display("vec %0d: up=%0b clr=%0b -> level=%0d at_max=%0b (exp %0d/%0d)",
                     i, tbl[i].up, tbl[i].clr, bus4.level, bus4.at_max,
                     tbl[i].exp_lvl, tbl[i].exp_max);
            chk("vec_level",  int'(bus4.level),  tbl[i].exp_lvl);
            chk("vec_at_max", int'(bus4.at_max), tbl[i].exp_max);
        end
        bus4.lvl_up  = 1'b0;
        bus4.lvl_clr = 1'b0;
        // din was captured at edge 64 (vector 15) from the level after vector 14
`ifdef LVL_WRAP_EN
        exp_din = 1;
`else
        exp_din = 9;
`endif
        chk("table_din", int'(bus4.din), exp_din);

        // ---------------- test 5: async reset mid-frame ----------------
        bus4.lvl_up = 1'b1;
        repeat (7) step();
        bus4.lvl_up = 1'b0;
        chk("pre_rst_level",  int'(bus4.level),  7);
        chk("pre_rst_at_max", int'(bus4.at_max), 0);
        guard = 0;
        while (bus4.scan != 2'b10 && guard < 64) begin
            step();
            guard++;
        end
        chk("wait_scan10_timeout", (guard < 64) ? 1 : 0, 1);
        chk("pre_rst_din", int'(bus4.din), exp_din);
        #2;
        rst = 1'b1;                        // between clock edges
        #1;
        $display("async reset: scan=%0d level=%0d din=%0d at_max=%0b",
                 bus4.scan, bus4.level, bus4.din, bus4.at_max);
        chk("arst_scan",   int'(bus4.scan),   0);
        chk("arst_level",  int'(bus4.level),  0);
        chk("arst_din",    int'(bus4.din),    0);
        chk("arst_at_max", int'(bus4.at_max), 0);
        #2;
        rst = 1'b0;
        k   = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_slot0", int'(bus4.scan), 0);
        end
        step();
        chk("post_rst_slot1", int'(bus4.scan), 1);

        // ---------------- test 6: DIV = 1 ----------------
        @(negedge clk);
        rst1        = 1'b0;
        k1          = 0;
        bus1.lvl_up = 1'b1;                // advance on edges 1, 2 and 5
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            k1++;
            exp_din = (k1 < 4) ? 0 : ((k1 < 8) ? 2 : 3);
            $display("div1 edge %0d: scan=%0d din=%0d level=%0d", k1, bus1.scan, bus1.din, bus1.level);
            chk("div1_scan", int'(bus1.scan), k1 % 4);
            chk("div1_din",  int'(bus1.din),  exp_din);
            bus1.lvl_up = (k1 == 1 || k1 == 4) ? 1'b1 : 1'b0;
        end
        chk("div1_level",  int'(bus1.level),  3);
        chk("div1_at_max", int'(bus1.at_max), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
